res_drain: RTL and testbench

Downstream drain stage for the result accumulator BRAM. On `start`, it reads `num_rows` 32-bit signed accumulators sequentially from the result BRAM read port and requantizes each one: multiply by `scale`, rounding right shift, optional ReLU, saturate to int8. Results stream out over a valid/ready interface with full throughput and backpressure, feeding the activation write-back path.

---
 rtl/res_drain.sv | 221 ++++++++++++++++++++++
 tb/tb_res_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/res_drain.sv
// res_drain: streams num_rows accumulators from the result BRAM, requantizes each to int8 and emits them over valid/ready.
// Optional build macro RES_DRAIN_RELU_EN enables the ReLU clamp. Latency: rd_en to out_valid is 3 cycles; reads are credit-throttled so the FIFO never overflows.

// Small generic FIFO; registered output, same-cycle write+read legal when full.
module res_drain_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             rd_vld_o,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic [CW-1:0]    cnt_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             wr_en, rd_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_en    = rd_rdy_i && (cnt_q != '0);
    assign wr_en    = wr_vld_i && ((cnt_q != CW'(DEPTH)) || rd_en);
    assign rd_vld_o = (cnt_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign cnt_o    = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (rd_en) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module res_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    num_rows,
    input  logic [SCALE_WIDTH-1:0] scale,
    input  logic [5:0]             shift,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last
);
    localparam int PW = DATA_WIDTH + SCALE_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [5:0]           SHIFT_MAX = 6'(PW - 1);
    localparam logic [ADDR_WIDTH:0]  ONE       = (ADDR_WIDTH + 1)'(1);
    localparam logic signed [PW:0]   EONE      = (PW + 1)'(1);
    localparam logic signed [PW:0]   SAT_MAX   = (EONE <<< (OUT_WIDTH - 1)) - EONE;
    localparam logic signed [PW:0]   SAT_MIN   = -(EONE <<< (OUT_WIDTH - 1));

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    rows_q, rows_d;
    logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
    logic [SCALE_WIDTH-1:0] scale_q, scale_d;
    logic [5:0]             shift_q, shift_d;
    logic                   s1_vld_q, s1_last_q;
    logic                   s2_vld_q, s2_last_q;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic signed [PW-1:0]   a_ext, b_ext;
    logic signed [PW:0]     rnd, sum, shifted;
    logic [OUT_WIDTH-1:0]   res;
    logic [CW-1:0]          fifo_cnt;
    logic [CW:0]            inflight;
    logic                   credit_ok, last_issue, hs_last;

`ifdef RES_DRAIN_RELU_EN
    logic relu_q, relu_d;
`else
    logic unused_relu;
    assign unused_relu = relu_en;
`endif

    // Occupancy counts reads already issued but not yet in the FIFO.
    assign inflight   = (CW + 1)'(fifo_cnt) + (CW + 1)'(s1_vld_q) + (CW + 1)'(s2_vld_q);
    assign credit_ok  = inflight < (CW + 1)'(FIFO_DEPTH);
    assign last_issue = (cnt_q + ONE) == rows_q;
    assign hs_last    = out_valid && out_ready && out_last;

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        scale_d = scale_q;
        shift_d = shift_q;
`ifdef RES_DRAIN_RELU_EN
        relu_d  = relu_q;
`endif
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d  = num_rows;
                    scale_d = scale;
                    shift_d = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
`ifdef RES_DRAIN_RELU_EN
                    relu_d  = relu_en;
`endif
                    cnt_d   = '0;
                    state_d = (num_rows == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    cnt_d = cnt_q + ONE;
                    if (last_issue) state_d = DRAIN;
                end
            end
            DRAIN:   if (hs_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_addr = cnt_q[ADDR_WIDTH-1:0];

    assign a_ext  = PW'($signed(rd_data));
    assign b_ext  = PW'($signed({1'b0, scale_q}));
    assign prod_d = a_ext * b_ext;

    // One extra bit keeps the rounding add from overflowing near full-scale products.
    always_comb begin
        rnd = '0;
        if (shift_q != 6'd0) rnd = EONE <<< (shift_q - 6'd1);
        sum     = {prod_q[PW-1], prod_q} + rnd;
        shifted = sum >>> shift_q;
`ifdef RES_DRAIN_RELU_EN
        if (relu_q && (shifted < 0)) shifted = '0;
`endif
        if (shifted > SAT_MAX)      res = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) res = SAT_MIN[OUT_WIDTH-1:0];
        else                        res = shifted[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cnt_q     <= '0;
            scale_q   <= '0;
            shift_q   <= '0;
`ifdef RES_DRAIN_RELU_EN
            relu_q    <= 1'b0;
`endif
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cnt_q     <= cnt_d;
            scale_q   <= scale_d;
            shift_q   <= shift_d;
`ifdef RES_DRAIN_RELU_EN
            relu_q    <= relu_d;
`endif
            s1_vld_q  <= rd_en;
            s1_last_q <= rd_en && last_issue;
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            if (s1_vld_q) prod_q <= prod_d;
        end
    end

    res_drain_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (s2_vld_q),
        .wr_dat_i ({s2_last_q, res}),
        .rd_vld_o (out_valid),
        .rd_rdy_i (out_ready),
        .rd_dat_o ({out_last, out_data}),
        .cnt_o    (fifo_cnt)
    );
endmodule

// File: tb/tb_res_drain.sv
// Scoreboard bench for res_drain: directed drains with hand-computed int8 results.
module tb_res_drain;
    logic        clk = 1'b0;
    logic        rst_n, start, relu_en;
    logic [10:0] num_rows;
    logic [15:0] scale;
    logic [5:0]  shift;
    logic        busy, done, rd_en, out_valid, out_last;
    logic        out_ready = 1'b1;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  out_data;

    always #5 clk = ~clk;

    res_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .scale(scale),
        .shift(shift), .relu_en(relu_en), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    logic signed [31:0] mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int dat; bit last;} exp_t;
    exp_t exp_q[$];

    int vectors = 0, errs = 0;
    int rd_total = 0, hs_total = 0, vld_total = 0;
    int rd_base = 0, hs_base = 0, vld_base = 0;
    int first_rd_cyc = 0, first_vld_cyc = 0, last_hs_cyc = 0, max_out = 0;
    int start_cyc = 0, rdy_mode = 0, dc = 0;

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push(input int d, input bit l);
        exp_t e;
        e.dat = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: read-address order, outstanding depth, and scoreboard pops on handshake.
    always @(negedge clk) begin
        exp_t e;
        int outst;
        if (rst_n) begin
            if (rd_en) begin
                if (rd_total == rd_base) first_rd_cyc = cyc;
                chk("rd_addr", int'(rd_addr), rd_total - rd_base);
                rd_total++;
            end
            outst = (rd_total - rd_base) - (hs_total - hs_base);
            if (outst > max_out) max_out = outst;
            if (out_valid) begin
                if (vld_total == vld_base) first_vld_cyc = cyc;
                vld_total++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_out: got %0d with empty scoreboard", int'($signed(out_data)));
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_data", int'($signed(out_data)), e.dat);
                    chk("out_last", int'(out_last), int'(e.last));
                    last_hs_cyc = cyc;
                    hs_total++;
                end else begin
                    chk("stall_hold", int'($signed(out_data)), exp_q[0].dat);
                end
            end
        end
    end

    always @(posedge clk) begin
        int rel;
        #1;
        rel = cyc - start_cyc;
        if (rdy_mode == 0)                out_ready = 1'b1;
        else if (rel >= 1 && rel <= 10)  out_ready = 1'b0;
        else if (rel > 10)               out_ready = ((rel - 11) % 2 == 0);
        else                             out_ready = 1'b1;
    end

    task automatic start_drain(input int n, input int sc, input int sh, input bit re);
        @(posedge clk); #1;
        num_rows = 11'(n); scale = 16'(sc); shift = 6'(sh); relu_en = re;
        start = 1'b1;
        start_cyc = cyc;
        rd_base = rd_total; hs_base = hs_total; vld_base = vld_total; max_out = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        bit found = 0;
        dcyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_after_start", int'(busy), 1);
            if (done) begin
                dcyc = cyc;
                found = 1;
                break;
            end
        end
        if (!found) begin
            vectors++; errs++;
            $display("FAIL done_timeout: got no done, required done within 3000 cycles");
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_busy"}, int'(busy), 0);
        chk({p, "_done"}, int'(done), 0);
        chk({p, "_rd_en"}, int'(rd_en), 0);
        chk({p, "_rd_addr"}, int'(rd_addr), 0);
        chk({p, "_out_valid"}, int'(out_valid), 0);
        chk({p, "_out_data"}, int'(out_data), 0);
        chk({p, "_out_last"}, int'(out_last), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; num_rows = '0; scale = '0; shift = '0; relu_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Basic drain with positive saturation and timing.
        mem[0] = 100; mem[1] = -100; mem[2] = 1000; mem[3] = 5;
        push(100, 0); push(-100, 0); push(127, 0); push(5, 1);
        start_drain(4, 1, 0, 0);
        wait_done(dc);
        chk("first_rd_latency", first_rd_cyc - start_cyc, 1);
        chk("first_valid_latency", first_vld_cyc - first_rd_cyc, 3);
        chk("last_hs_cycle", last_hs_cyc - first_rd_cyc, 6);
        chk("done_after_last", dc - last_hs_cyc, 1);

        // Rounding and negative saturation.
        mem[0] = 3; mem[1] = -3; mem[2] = -1000; mem[3] = 7;
        push(2, 0); push(-2, 0); push(-128, 0); push(5, 1);
        start_drain(4, 3, 2, 0);
        wait_done(dc);

        // ReLU (build dependent).
        mem[0] = -50; mem[1] = 40;
`ifdef RES_DRAIN_RELU_EN
        push(0, 0);
`else
        push(-50, 0);
`endif
        push(40, 1);
        start_drain(2, 1, 0, 1);
        wait_done(dc);

        // Shift above 47 clamps to 47; full-scale product rounding.
        mem[0] = 32'h7fffffff; mem[1] = 32'h80000000;
        push(1, 0); push(-1, 1);
        start_drain(2, 16'hffff, 63, 0);
        wait_done(dc);

        // Backpressure, with a start pulse while busy that must be ignored.
        for (int i = 0; i < 16; i++) begin
            mem[i] = i * 7 - 50;
            push(i * 7 - 50, i == 15);
        end
        rdy_mode = 1;
        start_drain(16, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1; start = 1'b1; num_rows = 11'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(dc);
        rdy_mode = 0;
        chk("bp_reads", rd_total - rd_base, 16);
        chk("bp_handshakes", hs_total - hs_base, 16);
        chk("bp_max_outstanding", max_out, 4);

        // Zero-length drain.
        start_drain(0, 1, 0, 0);
        wait_done(dc);
        chk("zero_done_cycle", dc - start_cyc, 1);
        chk("zero_reads", rd_total - rd_base, 0);
        chk("zero_valids", vld_total - vld_base, 0);

        // Reset mid-drain, then a clean 2-element drain.
        for (int i = 0; i < 10; i++) begin
            mem[i] = i + 1;
            push(i + 1, i == 9);
        end
        start_drain(10, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hs_total - hs_base >= 5) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            vectors++; errs++;
            $display("FAIL midrst_timeout: got %0d handshakes, required 5", hs_total - hs_base);
        end
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem[0] = 10; mem[1] = -20;
        push(10, 0); push(-20, 1);
        start_drain(2, 2, 1, 0);
        wait_done(dc);
        chk("post_rst_handshakes", hs_total - hs_base, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
